conv_layer_scheduler: RTL and testbench
=======================================

// Module: conv_layer_scheduler
// PURPOSE
//  Sequences one convolution layer on convolution_top: per output channel, kernel-load, stream all input channels, drain result.
//  Sits between the host/DMA control registers and convolution_top; owns oc/ic loop counters and checks AXIS frame lengths.
//  Drives Load_kernel_BRAM, Image_size and Channel_size; taps (does not drive) both AXIS handshakes.
// PARAMETERS
//  MAX_CH      256  largest legal channel count; sets width of channel indices (9 bits)
//  MAX_IMG     128  largest legal image side; frame beat counter holds MAX_IMG*MAX_IMG (15 bits)
// PORTS
//  clk               in   1   single clock, all logic on rising edge
//  aresetn           in   1   synchronous, active-low reset
//  start             in   1   1-cycle pulse; latches cfg_* and begins layer (ignored unless IDLE)
//  abort             in   1   level; forces IDLE next cycle from any state
//  cfg_image_size    in   8   image side; legal 4,8,16,32,64,128
//  cfg_in_ch         in   9   input channels, 1..MAX_CH
//  cfg_out_ch        in   9   output channels, 1..MAX_CH
//  kernel_load_ack   in   1   pulse from DMA: kernel+bias for current oc written
//  s_axis_tvalid/tready/tlast  in 1 each  input-stream tap
//  m_axis_tvalid/tready/tlast  in 1 each  output-stream tap
//  Load_kernel_BRAM  out  1   high throughout LOAD_KERNEL
//  Image_size        out  8   latched cfg_image_size
//  Channel_size      out  9   latched cfg_in_ch
//  in_dma_req        out  1   high throughout STREAM_IN
//  oc_idx / ic_idx   out  9   current output / input channel
//  busy              out  1   state != IDLE
//  done              out  1   1-cycle pulse on layer completion
//  cfg_err           out  1   sticky; set on illegal start, cleared by next legal start
//  frame_err         out  1   sticky; set on bad frame length/stray tlast, cleared by legal start
// BEHAVIOUR
//  Reset (aresetn=0 at edge): state IDLE; all outputs 0 incl. latched Image_size/Channel_size, sticky flags.
//  States: IDLE -> LOAD_KERNEL -> STREAM_IN -> DRAIN_OUT -> (LOAD_KERNEL | DONE) -> IDLE.
//  IDLE: start with legal cfg -> LOAD_KERNEL next cycle, Load_kernel_BRAM=1 that cycle (latency 1); oc=ic=0.
//   illegal cfg (size not in set, ch=0, ch>MAX_CH) -> stay IDLE, cfg_err=1 next cycle.
//  LOAD_KERNEL: wait kernel_load_ack -> STREAM_IN; Load_kernel_BRAM drops same edge.
//  STREAM_IN: s beat = tvalid&tready; beat counter ++ per beat. On beat with tlast:
//   len==size*size else frame_err=1 (still advances); ic==cfg_in_ch-1 -> DRAIN_OUT else ic++.
//  DRAIN_OUT: m beat with tlast -> ic=0; oc==cfg_out_ch-1 -> DONE else oc++, LOAD_KERNEL.
//   m beat count also checked == size*size at tlast (frame_err).
//  DONE: done=1 for exactly one cycle, then IDLE; oc/ic hold final values until next start.
//  Stray tlast: s tlast outside STREAM_IN or m tlast outside DRAIN_OUT -> frame_err=1, no transition.
//  Beat counter saturates at size*size+1 (no wrap); cleared on each tlast beat and state entry.
//  Simultaneous: abort wins over every transition; start during busy ignored; ack outside LOAD_KERNEL ignored.
//  abort: IDLE next cycle, Load_kernel_BRAM/in_dma_req/busy 0, no done pulse, sticky flags kept.
//  Size*size computed as left shift by log2(size); no multiplier.
// STRUCTURE
//  conv_sched_pkg: state encoding localparams, legal size list, log2 lookup, width constants.
//  Sub-module axis_frame_checker (x2, one per stream): beat counter, expected length, tlast/err outputs.
//  FSM + oc/ic counters + config latch stay in this module.
// TESTING
//  1 size=4,in=2,out=2; ack 3 cyc after load; 16-beat frames -> 4 in frames, 2 out frames, done at end, no errs.
//  2 start with size=12 -> cfg_err=1, busy stays 0; then legal start -> cfg_err clears, busy=1 next cycle.
//  3 size=8, input tlast on beat 63 -> frame_err=1, ic still advances, layer completes with done.
//  4 abort asserted mid STREAM_IN (ic=1) -> next cycle IDLE, in_dma_req=0, no done; restart runs clean.
//  5 aresetn=0 mid DRAIN_OUT -> all outputs 0 next edge; m tlast afterwards -> frame_err=1 (stray).
//  6 start pulsed while busy and ack pulsed during STREAM_IN -> both ignored, sequence unchanged.

Source files
------------

// File: rtl/conv_layer_scheduler_pkg.sv
// Shared constants, FSM state type and image-size helpers for the layer scheduler.
package conv_layer_scheduler_pkg;

  localparam int unsigned MAX_CH  = 256;
  localparam int unsigned MAX_IMG = 128;
  localparam int unsigned SIZE_W  = 8;
  localparam int unsigned CH_W    = 9;
  localparam int unsigned LEN_W   = 15;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOAD_KERNEL = 3'd1,
    STREAM_IN   = 3'd2,
    DRAIN_OUT   = 3'd3,
    DONE        = 3'd4
  } sched_state_t;

  // log2 of a legal image side; non-power-of-two sides map to 0
  function automatic logic [2:0] size_log2(input logic [SIZE_W-1:0] size);
    logic [2:0] l;
    l = 3'd0;
    case (size)
      8'd4:    l = 3'd2;
      8'd8:    l = 3'd3;
      8'd16:   l = 3'd4;
      8'd32:   l = 3'd5;
      8'd64:   l = 3'd6;
      8'd128:  l = 3'd7;
      default: l = 3'd0;
    endcase
    return l;
  endfunction

  function automatic logic size_legal(input logic [SIZE_W-1:0] size,
                                      input int unsigned max_img);
    return (size_log2(size) != 3'd0) && (int'(size) <= int'(max_img));
  endfunction

  // size*size as 1 << (2*log2(size))
  function automatic logic [LEN_W-1:0] frame_len(input logic [SIZE_W-1:0] size);
    logic [LEN_W-1:0] one;
    one = LEN_W'(1);
    return one << {size_log2(size), 1'b0};
  endfunction

endpackage

// File: rtl/conv_layer_scheduler_if.sv
// Tap of both AXI-stream handshakes around convolution_top.
interface conv_layer_scheduler_if;
  logic s_axis_tvalid;
  logic s_axis_tready;
  logic s_axis_tlast;
  logic m_axis_tvalid;
  logic m_axis_tready;
  logic m_axis_tlast;

  modport master (
    output s_axis_tvalid, s_axis_tready, s_axis_tlast,
    output m_axis_tvalid, m_axis_tready, m_axis_tlast
  );

  modport slave (
    input s_axis_tvalid, s_axis_tready, s_axis_tlast,
    input m_axis_tvalid, m_axis_tready, m_axis_tlast
  );
endinterface

// File: rtl/conv_layer_scheduler_axis_frame_checker.sv
// Counts beats of one AXI stream while enabled and flags frames of the wrong
// length, plus any tlast beat seen while the stream is not expected.
module axis_frame_checker
  import conv_layer_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             aresetn,
  input  logic             enable,
  input  logic [LEN_W-1:0] exp_len,
  input  logic             tvalid,
  input  logic             tready,
  input  logic             tlast,
  output logic             frame_end,
  output logic             len_err
);

  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_inc;
  logic             beat;

  // beat decode and length check on the tlast beat (count includes that beat)
  always_comb begin
    beat      = tvalid & tready;
    cnt_inc   = cnt + LEN_W'(1);
    frame_end = beat & tlast & enable;
    len_err   = beat & tlast & (enable ? (cnt_inc != exp_len) : 1'b1);
  end

  // beat counter: idle outside the owning state, saturates at exp_len+1
  always_ff @(posedge clk) begin
    if (!aresetn || !enable) begin
      cnt <= '0;
    end else if (beat) begin
      if (tlast)
        cnt <= '0;
      else if (cnt <= exp_len)
        cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/conv_layer_scheduler.sv
// Sequences one convolution layer: per output channel load the kernel, stream
// every input channel, then drain the result frame.
module conv_layer_scheduler
  import conv_layer_scheduler_pkg::*;
#(
  parameter int unsigned MAX_CH  = conv_layer_scheduler_pkg::MAX_CH,
  parameter int unsigned MAX_IMG = conv_layer_scheduler_pkg::MAX_IMG
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [SIZE_W-1:0]     cfg_image_size,
  input  logic [CH_W-1:0]       cfg_in_ch,
  input  logic [CH_W-1:0]       cfg_out_ch,
  input  logic                  kernel_load_ack,
  conv_layer_scheduler_if.slave axis,
  output logic                  Load_kernel_BRAM,
  output logic [SIZE_W-1:0]     Image_size,
  output logic [CH_W-1:0]       Channel_size,
  output logic                  in_dma_req,
  output logic [CH_W-1:0]       oc_idx,
  output logic [CH_W-1:0]       ic_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  frame_err
);

  sched_state_t     state;
  logic [CH_W-1:0]  out_ch;
  logic [LEN_W-1:0] exp_len;
  logic             cfg_ok;
  logic             start_req;
  logic             s_end, s_err, m_end, m_err;

  // config legality and expected frame length from the latched size
  always_comb begin
    cfg_ok = size_legal(cfg_image_size, MAX_IMG)
           && (cfg_in_ch  != '0) && (int'(cfg_in_ch)  <= int'(MAX_CH))
           && (cfg_out_ch != '0) && (int'(cfg_out_ch) <= int'(MAX_CH));
    start_req = (state == IDLE) && start && !abort;
    exp_len   = frame_len(Image_size);
  end

  axis_frame_checker u_s_chk (
    .clk       (clk),
    .aresetn   (aresetn),
    .enable    (state == STREAM_IN),
    .exp_len   (exp_len),
    .tvalid    (axis.s_axis_tvalid),
    .tready    (axis.s_axis_tready),
    .tlast     (axis.s_axis_tlast),
    .frame_end (s_end),
    .len_err   (s_err)
  );

  axis_frame_checker u_m_chk (
    .clk       (clk),
    .aresetn   (aresetn),
    .enable    (state == DRAIN_OUT),
    .exp_len   (exp_len),
    .tvalid    (axis.m_axis_tvalid),
    .tready    (axis.m_axis_tready),
    .tlast     (axis.m_axis_tlast),
    .frame_end (m_end),
    .len_err   (m_err)
  );

  // layer FSM with registered outputs, channel counters and config latch;
  // frame errors are recorded even on the abort cycle, and a new error on the
  // accepting start cycle wins over the clear
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state            <= IDLE;
      Load_kernel_BRAM <= 1'b0;
      in_dma_req       <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      cfg_err          <= 1'b0;
      frame_err        <= 1'b0;
      Image_size       <= '0;
      Channel_size     <= '0;
      out_ch           <= '0;
      oc_idx           <= '0;
      ic_idx           <= '0;
    end else begin
      done <= 1'b0;
      if (start_req && cfg_ok)
        frame_err <= 1'b0;
      if (s_err || m_err)
        frame_err <= 1'b1;

      if (abort) begin
        state            <= IDLE;
        Load_kernel_BRAM <= 1'b0;
        in_dma_req       <= 1'b0;
        busy             <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_req) begin
              if (cfg_ok) begin
                state            <= LOAD_KERNEL;
                Load_kernel_BRAM <= 1'b1;
                busy             <= 1'b1;
                cfg_err          <= 1'b0;
                Image_size       <= cfg_image_size;
                Channel_size     <= cfg_in_ch;
                out_ch           <= cfg_out_ch;
                oc_idx           <= '0;
                ic_idx           <= '0;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          LOAD_KERNEL: begin
            if (kernel_load_ack) begin
              state            <= STREAM_IN;
              Load_kernel_BRAM <= 1'b0;
              in_dma_req       <= 1'b1;
            end
          end
          STREAM_IN: begin
            if (s_end) begin
              if (ic_idx == Channel_size - CH_W'(1)) begin
                state      <= DRAIN_OUT;
                in_dma_req <= 1'b0;
              end else begin
                ic_idx <= ic_idx + CH_W'(1);
              end
            end
          end
          DRAIN_OUT: begin
            if (m_end) begin
              ic_idx <= '0;
              if (oc_idx == out_ch - CH_W'(1)) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                oc_idx           <= oc_idx + CH_W'(1);
                state            <= LOAD_KERNEL;
                Load_kernel_BRAM <= 1'b1;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed bench for conv_layer_scheduler: stimulus pushes expected
// kernel-load / done events into a scoreboard, a monitor pops them as the DUT
// raises Load_kernel_BRAM or done; spot checks cover reset, abort and errors.
module tb_conv_layer_scheduler;

  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] cfg_image_size = '0;
  logic [8:0] cfg_in_ch = '0;
  logic [8:0] cfg_out_ch = '0;
  logic       kernel_load_ack = 1'b0;
  logic       Load_kernel_BRAM;
  logic [7:0] Image_size;
  logic [8:0] Channel_size;
  logic       in_dma_req;
  logic [8:0] oc_idx, ic_idx;
  logic       busy, done, cfg_err, frame_err;

  conv_layer_scheduler_if axis ();

  conv_layer_scheduler dut (
    .clk              (clk),
    .aresetn          (aresetn),
    .start            (start),
    .abort            (abort),
    .cfg_image_size   (cfg_image_size),
    .cfg_in_ch        (cfg_in_ch),
    .cfg_out_ch       (cfg_out_ch),
    .kernel_load_ack  (kernel_load_ack),
    .axis             (axis.slave),
    .Load_kernel_BRAM (Load_kernel_BRAM),
    .Image_size       (Image_size),
    .Channel_size     (Channel_size),
    .in_dma_req       (in_dma_req),
    .oc_idx           (oc_idx),
    .ic_idx           (ic_idx),
    .busy             (busy),
    .done             (done),
    .cfg_err          (cfg_err),
    .frame_err        (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int oc;
    int ic;
    bit ferr;
  } ev_t;

  ev_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;
  bit  lk_q = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input bit is_done, input int oc, input int ic, input bit ferr);
    ev_t e;
    e.is_done = is_done;
    e.oc = oc;
    e.ic = ic;
    e.ferr = ferr;
    sb.push_back(e);
  endtask

  // monitor: every kernel-load rise and every done pulse must match the next expected event
  task automatic observe(input bit is_done);
    ev_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_event: got kind %0d oc %0d expected none", is_done, oc_idx);
    end else begin
      e = sb.pop_front();
      check("ev_kind", int'(is_done), int'(e.is_done));
      check("ev_oc", int'(oc_idx), e.oc);
      check("ev_ic", int'(ic_idx), e.ic);
      check("ev_ferr", int'(frame_err), int'(e.ferr));
    end
  endtask

  always @(negedge clk) begin
    if (Load_kernel_BRAM && !lk_q) observe(1'b0);
    if (done) observe(1'b1);
    lk_q = Load_kernel_BRAM;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int size, input int in_ch, input int out_ch);
    cfg_image_size = 8'(size);
    cfg_in_ch      = 9'(in_ch);
    cfg_out_ch     = 9'(out_ch);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_ack();
    kernel_load_ack = 1'b1;
    tick(1);
    kernel_load_ack = 1'b0;
  endtask

  // one frame of len beats on the input (sel=0) or output (sel=1) stream
  task automatic send(input bit sel, input int len, input bit with_last);
    for (int i = 0; i < len; i++) begin
      if (sel) begin
        axis.m_axis_tvalid = 1'b1;
        axis.m_axis_tready = 1'b1;
        axis.m_axis_tlast  = with_last && (i == len - 1);
      end else begin
        axis.s_axis_tvalid = 1'b1;
        axis.s_axis_tready = 1'b1;
        axis.s_axis_tlast  = with_last && (i == len - 1);
      end
      tick(1);
    end
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tready = 1'b0;
    axis.s_axis_tlast  = 1'b0;
    axis.m_axis_tvalid = 1'b0;
    axis.m_axis_tready = 1'b0;
    axis.m_axis_tlast  = 1'b0;
  endtask

  // full legal layer; first_len sets the length of the very first input frame,
  // poke adds a start during busy and an ack during STREAM_IN
  task automatic layer(input int size, input int in_ch, input int out_ch,
                       input int first_len, input bit poke);
    int len;
    bit bad;
    len = size * size;
    bad = (first_len != len);
    push(1'b0, 0, 0, 1'b0);
    do_start(size, in_ch, out_ch);
    check("start_busy", int'(busy), 1);
    check("start_cfg_err", int'(cfg_err), 0);
    check("start_img", int'(Image_size), size);
    check("start_ch", int'(Channel_size), in_ch);
    for (int oc = 0; oc < out_ch; oc++) begin
      tick(1);
      if (poke && oc == 0) begin
        do_start(12, 3, 3);
        check("busy_start_img", int'(Image_size), size);
        check("busy_start_cfg_err", int'(cfg_err), 0);
      end else begin
        tick(1);
      end
      tick(1);
      check("lk_held", int'(Load_kernel_BRAM), 1);
      pulse_ack();
      check("in_dma_req", int'(in_dma_req), 1);
      check("lk_drop", int'(Load_kernel_BRAM), 0);
      if (poke && oc == 0) begin
        pulse_ack();
        check("stray_ack_dma", int'(in_dma_req), 1);
        check("stray_ack_lk", int'(Load_kernel_BRAM), 0);
      end
      for (int ic = 0; ic < in_ch; ic++) begin
        send(1'b0, (oc == 0 && ic == 0) ? first_len : len, 1'b1);
        if (oc == 0 && ic == 0 && in_ch > 1) begin
          check("ic_adv", int'(ic_idx), 1);
          check("ferr_after_first", int'(frame_err), int'(bad));
        end
      end
      check("drain_dma_low", int'(in_dma_req), 0);
      if (oc == out_ch - 1) push(1'b1, out_ch - 1, 0, bad);
      else                  push(1'b0, oc + 1, 0, bad);
      send(1'b1, len, 1'b1);
    end
    tick(2);
    check("end_busy", int'(busy), 0);
    check("end_oc_hold", int'(oc_idx), out_ch - 1);
  endtask

  initial begin
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tready = 1'b0;
    axis.s_axis_tlast  = 1'b0;
    axis.m_axis_tvalid = 1'b0;
    axis.m_axis_tready = 1'b0;
    axis.m_axis_tlast  = 1'b0;
    tick(3);
    check("rst_busy", int'(busy), 0);
    check("rst_lk", int'(Load_kernel_BRAM), 0);
    check("rst_img", int'(Image_size), 0);
    check("rst_ferr", int'(frame_err), 0);
    aresetn = 1'b1;
    tick(1);

    // 1: nominal 4x4, 2 in, 2 out
    layer(4, 2, 2, 16, 1'b0);
    check("t1_frame_err", int'(frame_err), 0);

    // 2: illegal size then legal start
    do_start(12, 1, 1);
    check("t2_cfg_err", int'(cfg_err), 1);
    check("t2_busy", int'(busy), 0);
    tick(1);
    layer(4, 1, 1, 16, 1'b0);

    // 3: short first input frame of an 8x8 layer
    layer(8, 2, 1, 63, 1'b0);
    check("t3_ferr_sticky", int'(frame_err), 1);

    // 4: abort mid STREAM_IN, then a clean restart
    push(1'b0, 0, 0, 1'b0);
    do_start(4, 2, 1);
    tick(3);
    pulse_ack();
    send(1'b0, 16, 1'b1);
    check("t4_ic", int'(ic_idx), 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t4_busy", int'(busy), 0);
    check("t4_dma", int'(in_dma_req), 0);
    check("t4_lk", int'(Load_kernel_BRAM), 0);
    tick(3);
    layer(4, 1, 1, 16, 1'b0);

    // 5: reset during DRAIN_OUT, then a stray output tlast
    push(1'b0, 0, 0, 1'b0);
    do_start(4, 1, 2);
    tick(3);
    pulse_ack();
    send(1'b0, 16, 1'b1);
    check("t5_drain_busy", int'(busy), 1);
    send(1'b1, 5, 1'b0);
    aresetn = 1'b0;
    tick(1);
    check("t5_busy", int'(busy), 0);
    check("t5_img", int'(Image_size), 0);
    check("t5_ch", int'(Channel_size), 0);
    check("t5_oc", int'(oc_idx), 0);
    check("t5_cfg_err", int'(cfg_err), 0);
    check("t5_ferr", int'(frame_err), 0);
    aresetn = 1'b1;
    tick(1);
    send(1'b1, 1, 1'b1);
    check("t5_stray_ferr", int'(frame_err), 1);
    check("t5_stray_busy", int'(busy), 0);

    // 6: start while busy and ack during STREAM_IN are ignored
    layer(4, 2, 1, 16, 1'b1);

    tick(4);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
